// File: rtl/obsidian_memory_stage.sv
// Obsidian memory-access stage: multi-cycle word RAM load/store, branch decode, MEM_WB register.
// Optional misaligned-access trap enabled by defining OBSIDIAN_MEM_MISALIGN_TRAP_EN.
module obsidian_memory_stage #(
   parameter int MEM_DEPTH_LOG2 = 8,
   parameter int MEM_LATENCY    = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [106:0] EX_MEM,
   output logic [70:0]  MEM_WB,
   output logic         stall,
   output logic         PCSrc,
   output logic [31:0]  branch_target,
   output logic         misalign_err
);

   localparam int         DEPTH = 1 << MEM_DEPTH_LOG2;
   localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

   logic                      reg_write, mem_to_reg, branch, mem_read, mem_write, zero;
   logic [31:0]               alu_result, store_data;
   logic [4:0]                rd;
   logic [MEM_DEPTH_LOG2-1:0] idx;

   assign reg_write  = EX_MEM[106];
   assign mem_to_reg = EX_MEM[105];
   assign branch     = EX_MEM[104];
   assign mem_read   = EX_MEM[103];
   assign mem_write  = EX_MEM[102];
   assign zero       = EX_MEM[69];
   assign alu_result = EX_MEM[68:37];
   assign store_data = EX_MEM[36:5];
   assign rd         = EX_MEM[4:0];
   assign idx        = EX_MEM[37+2 +: MEM_DEPTH_LOG2];

   assign PCSrc         = branch & zero;
   assign branch_target = EX_MEM[101:70];

   logic [3:0]  cnt_q, cnt_d;
   logic [70:0] mem_wb_q, mem_wb_d;
   logic        misalign_q, misalign_d;
   logic        access, misalign, wr_en;
   logic [31:0] ram [DEPTH];
   logic [31:0] rd_word;

   assign access  = mem_read | mem_write;
   assign rd_word = ram[idx];

`ifdef OBSIDIAN_MEM_MISALIGN_TRAP_EN
   assign misalign = access & (alu_result[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Held low during reset so upstream is never frozen by a cleared counter.
   assign stall = access & (cnt_q != LAT) & ~rst;

   always_comb begin
      cnt_d      = cnt_q;
      mem_wb_d   = mem_wb_q;
      misalign_d = misalign_q;
      wr_en      = 1'b0;
      if (stall) begin
         cnt_d    = cnt_q + 4'd1;
         mem_wb_d = '0;
      end else begin
         cnt_d    = 4'd0;
         mem_wb_d = {reg_write & ~misalign, mem_to_reg,
                     (mem_read & ~misalign) ? rd_word : 32'd0,
                     alu_result, rd};
         wr_en    = mem_write & ~misalign & ~rst;
         if (misalign) misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= 4'd0;
         mem_wb_q   <= '0;
         misalign_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mem_wb_q   <= mem_wb_d;
         misalign_q <= misalign_d;
      end
   end

   // RAM contents survive reset; only the write strobe is qualified.
   always_ff @(posedge clk) begin
      if (wr_en) ram[idx] <= store_data;
   end

   assign MEM_WB       = mem_wb_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_obsidian_memory_stage.sv
// Randomized bench for obsidian_memory_stage against a transaction-level memory model.
module tb_obsidian_memory_stage;
   localparam int LAT = 2;
   localparam int DL2 = 8;
`ifdef OBSIDIAN_MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [106:0] ex_mem;
   logic [70:0]  mem_wb;
   logic         stall, pcsrc, misalign_err;
   logic [31:0]  btgt;

   obsidian_memory_stage #(.MEM_DEPTH_LOG2(DL2), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .EX_MEM(ex_mem), .MEM_WB(mem_wb), .stall(stall),
      .PCSrc(pcsrc), .branch_target(btgt), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] ref_mem [int];
   logic        ref_mis = 1'b0;

   task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [106:0] mk(input bit rw, input bit mtr, input bit br, input bit mr,
                                       input bit mw, input logic [31:0] tgt, input bit z,
                                       input logic [31:0] alu, input logic [31:0] sd,
                                       input logic [4:0] rd);
      return {rw, mtr, br, mr, mw, tgt, z, alu, sd, rd};
   endfunction

   // Apply one instruction, check every cycle until it retires, update the model.
   task automatic run(input logic [106:0] ex);
      bit          rw, mtr, br, mr, mw, z, acc, mis;
      logic [31:0] tgt, alu, sd, ld;
      logic [4:0]  rd;
      int          w;
      {rw, mtr, br, mr, mw, tgt, z, alu, sd, rd} = ex;
      ex_mem = ex;
      #1;
      acc = mr | mw;
      if (acc) begin
         for (int i = 0; i < LAT; i++) begin
            chk("stall_hi", {70'd0, stall}, 71'd1);
            chk("pcsrc", {70'd0, pcsrc}, {70'd0, br & z});
            chk("btgt", {39'd0, btgt}, {39'd0, tgt});
            tick();
            chk("bubble", mem_wb, 71'd0);
         end
      end
      chk("stall_lo", {70'd0, stall}, 71'd0);
      chk("pcsrc", {70'd0, pcsrc}, {70'd0, br & z});
      chk("btgt", {39'd0, btgt}, {39'd0, tgt});
      tick();
      w   = int'((alu >> 2) % (1 << DL2));
      mis = TRAP && acc && (alu % 4 != 0);
      ld  = 32'd0;
      if (mr && !mis) ld = ref_mem.exists(w) ? ref_mem[w] : 32'hxxxx_xxxx;
      if (mw && !mis) ref_mem[w] = sd;
      if (mis) ref_mis = 1'b1;
      chk("mem_wb", mem_wb, {rw & ~mis, mtr, ld, alu, rd});
      chk("misalign", {70'd0, misalign_err}, {70'd0, ref_mis});
   endtask

   initial begin
      rst    = 1'b1;
      ex_mem = '0;
      repeat (2) tick();
      chk("rst_mem_wb", mem_wb, 71'd0);
      chk("rst_stall", {70'd0, stall}, 71'd0);
      chk("rst_misalign", {70'd0, misalign_err}, 71'd0);
      rst = 1'b0;
      tick();

      // ADD pass-through
      run(mk(1, 0, 0, 0, 0, 32'd0, 0, 32'h10, 32'd0, 5'd5));
      chk("add_exact", mem_wb, {1'b1, 1'b0, 32'd0, 32'h10, 5'd5});

      // Prefill the low 16 words
      for (int i = 0; i < 16; i++)
         run(mk(0, 0, 0, 0, 1, 32'd0, 0, 32'(i * 4), $urandom, 5'd0));

      // Store / load round trip
      run(mk(0, 0, 0, 0, 1, 32'd0, 0, 32'h8, 32'hDEADBEEF, 5'd0));
      run(mk(1, 1, 0, 1, 0, 32'd0, 0, 32'h8, 32'd0, 5'd3));
      chk("ld_deadbeef", mem_wb, {1'b1, 1'b1, 32'hDEADBEEF, 32'h8, 5'd3});

      // Address wrap
      run(mk(0, 0, 0, 0, 1, 32'd0, 0, 32'h400, 32'h1234, 5'd0));
      run(mk(1, 1, 0, 1, 0, 32'd0, 0, 32'h0, 32'd0, 5'd9));
      chk("ld_wrap", mem_wb[68:37], {39'd0, 32'h1234});

      // Read+write: pre-write data returned
      run(mk(1, 1, 0, 1, 1, 32'd0, 0, 32'hC, 32'hA5A5_0001, 5'd4));
      run(mk(1, 1, 0, 1, 0, 32'd0, 0, 32'hC, 32'd0, 5'd4));
      chk("rmw_after", mem_wb[68:37], {39'd0, 32'hA5A5_0001});

      // Branch decode
      run(mk(0, 0, 1, 0, 0, 32'h40, 1, 32'd0, 32'd0, 5'd0));
      run(mk(0, 0, 1, 0, 0, 32'h40, 0, 32'd0, 32'd0, 5'd0));

      // Reset during the second stall cycle of a store
      run(mk(0, 0, 0, 0, 1, 32'd0, 0, 32'h10, 32'hCAFEF00D, 5'd0));
      ex_mem = mk(0, 0, 0, 0, 1, 32'd0, 0, 32'h10, 32'h0BAD0BAD, 5'd0);
      tick();
      chk("pre_rst_stall", {70'd0, stall}, 71'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_mem_wb", mem_wb, 71'd0);
      chk("rst_mid_stall", {70'd0, stall}, 71'd0);
      ex_mem = '0;
      tick();
      chk("rst_hold_stall", {70'd0, stall}, 71'd0);
      rst = 1'b0;
      ref_mis = 1'b0;
      run(mk(1, 1, 0, 1, 0, 32'd0, 0, 32'h10, 32'd0, 5'd2));
      chk("rst_dropped_store", mem_wb[68:37], {39'd0, 32'hCAFEF00D});

      // Misaligned load
      run(mk(0, 0, 0, 0, 1, 32'd0, 0, 32'h4, 32'h55AA_1234, 5'd0));
      run(mk(1, 1, 0, 1, 0, 32'd0, 0, 32'h6, 32'd0, 5'd7));
      chk("misalign_ld", mem_wb[68:37], {39'd0, TRAP ? 32'd0 : 32'h55AA_1234});
      run(mk(1, 0, 0, 0, 0, 32'd0, 0, 32'h99, 32'd0, 5'd1));

      // Randomized traffic over the prefilled region, with upper-bit aliasing
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         run(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, 1'($urandom), a, $urandom, 5'($urandom)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
